// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side bundle for mem_port_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_port_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        req_we;
  logic [NREQ-1:0][31:0]  req_addr;
  logic [NREQ-1:0][31:0]  req_wdata;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        rsp_valid;
  logic [31:0]            rsp_data;
  logic [31:0]            mem_raddr;
  logic [31:0]            mem_rdata;
  logic                   mem_wen;
  logic [31:0]            mem_waddr;
  logic [31:0]            mem_wdata;

  modport slave (
    input  req, req_we, req_addr, req_wdata, mem_rdata,
    output gnt, rsp_valid, rsp_data, mem_raddr, mem_wen, mem_waddr, mem_wdata
  );

  modport master (
    output req, req_we, req_addr, req_wdata, mem_rdata,
    input  gnt, rsp_valid, rsp_data, mem_raddr, mem_wen, mem_waddr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter with bounded bursts sharing the memory's second read port
// and write port among NREQ requesters. Read data returns RD_LAT cycles after
// the grant and is steered back to its issuer by a tag shift register.
module mem_port_arbiter #(
  parameter int NREQ      = 2,
  parameter int RD_LAT    = 2,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  // burst_cnt only needs to reach MAX_BURST-1; it saturates there so a lone
  // requester streaming for a long time cannot wrap and starve the others.
  localparam int BW     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int STAGES = RD_LAT - 1;

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] owner;
  logic          owner_vld;
  logic [BW-1:0] burst_cnt;

  logic          gnt_any;
  logic [IW-1:0] gidx;
  logic          gnt_rd;

  logic [STAGES:0]         vld_pipe;
  logic [STAGES:0][IW-1:0] tag_pipe;

  // Pick the grantee: continue the owner's burst if allowed, else round-robin scan
  always_comb begin
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gidx    = '0;
    if (owner_vld && bus.req[owner] && (int'(burst_cnt) < MAX_BURST - 1)) begin
      gnt_any = 1'b1;
      gidx    = owner;
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = (int'(rr_ptr) + k) % NREQ;
        if (!gnt_any && bus.req[idx]) begin
          gnt_any = 1'b1;
          gidx    = IW'(idx);
        end
      end
    end
  end

  // Drive grant and memory ports from the grantee; handshakes are masked in reset
  always_comb begin
    bus.gnt       = '0;
    bus.mem_raddr = '0;
    bus.mem_waddr = '0;
    bus.mem_wdata = '0;
    bus.mem_wen   = 1'b0;
    gnt_rd        = 1'b0;
    if (gnt_any) begin
      bus.mem_raddr = bus.req_addr[gidx];
      bus.mem_waddr = bus.req_addr[gidx];
      bus.mem_wdata = bus.req_wdata[gidx];
      gnt_rd        = ~bus.req_we[gidx];
      if (rst_n) begin
        bus.gnt[gidx] = 1'b1;
        bus.mem_wen   = bus.req_we[gidx];
      end
    end
  end

  // Grant state: rr pointer, burst owner and its consecutive-grant count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= IW'(NREQ - 1);
      owner     <= '0;
      owner_vld <= 1'b0;
      burst_cnt <= '0;
    end else if (gnt_any) begin
      rr_ptr    <= gidx;
      owner     <= gidx;
      owner_vld <= 1'b1;
      if (owner_vld && (gidx == owner))
        burst_cnt <= (burst_cnt == BW'(MAX_BURST - 1)) ? burst_cnt : burst_cnt + 1'b1;
      else
        burst_cnt <= '0;
    end else begin
      owner_vld <= 1'b0;
      burst_cnt <= '0;
    end
  end

  // Tag pipe: one entry per cycle, valid only for granted reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      vld_pipe[0] <= gnt_any & gnt_rd;
      tag_pipe[0] <= gidx;
      for (int s = 1; s <= STAGES; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        tag_pipe[s] <= tag_pipe[s-1];
      end
    end
  end

  // Steer returning read data to the issuer recorded RD_LAT cycles ago
  always_comb begin
    bus.rsp_valid = '0;
    bus.rsp_data  = bus.mem_rdata;
    if (vld_pipe[STAGES] && rst_n)
      bus.rsp_valid[tag_pipe[STAGES]] = 1'b1;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter. A 2-requester instance
// is scored cycle by cycle against a grant/response model; a 3-requester
// MAX_BURST=1 instance checks strict alternation.
module tb_mem_port_arbiter;
  localparam int NA = 2;
  localparam int MB = 4;
  localparam int RL = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.NREQ(NA)) ifa ();
  mem_port_arbiter_if #(.NREQ(3))  ifb ();

  mem_port_arbiter #(.NREQ(NA), .RD_LAT(RL), .MAX_BURST(MB)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave)
  );
  mem_port_arbiter #(.NREQ(3), .RD_LAT(RL), .MAX_BURST(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave)
  );

  // Memory for instance A: 16-bit byte address space, 2-cycle read latency
  logic [31:0] mem [16384];
  logic [31:0] rd1, rd2;
  always @(posedge clk) begin
    if (ifa.mem_wen) mem[ifa.mem_waddr[15:2]] <= ifa.mem_wdata;
    rd1 <= mem[ifa.mem_raddr[15:2]];
    rd2 <= rd1;
  end
  assign ifa.mem_rdata = rd2;
  assign ifb.mem_rdata = 32'h0;

  // Reference model state
  typedef struct { int due; int idx; logic [31:0] data; } rsp_t;
  rsp_t        q[$];
  logic [31:0] shadow [16384];
  int m_last, m_run, m_rr, cyc;
  int n_chk, n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_last = -1;
    m_run  = 0;
    m_rr   = NA - 1;
  endtask

  // One clock of instance A: drive, score combinational outputs and
  // responses, then advance the model across the posedge.
  task automatic cycle(input logic [1:0] r, input logic [1:0] we,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
    int          g;
    logic [31:0] ga, gd;
    @(negedge clk);
    ifa.req          = r;
    ifa.req_we       = we;
    ifa.req_addr[0]  = a0;
    ifa.req_addr[1]  = a1;
    ifa.req_wdata[0] = d0;
    ifa.req_wdata[1] = d1;
    #1;
    g = -1;
    if (m_last >= 0 && r[m_last] && m_run < MB) g = m_last;
    else
      for (int k = 1; k <= NA; k++)
        if (g < 0 && r[(m_rr + k) % NA]) g = (m_rr + k) % NA;
    ga = (g == 1) ? a1 : a0;
    gd = (g == 1) ? d1 : d0;
    chk("gnt", 32'(ifa.gnt), (g < 0) ? 32'h0 : (32'h1 << g));
    if (g >= 0) begin
      chk("mem_wen", 32'(ifa.mem_wen), 32'(we[g]));
      if (we[g]) begin
        chk("mem_waddr", ifa.mem_waddr, ga);
        chk("mem_wdata", ifa.mem_wdata, gd);
      end else begin
        chk("mem_raddr", ifa.mem_raddr, ga);
      end
    end else begin
      chk("mem_wen_idle", 32'(ifa.mem_wen), 32'h0);
    end
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("rsp_valid", 32'(ifa.rsp_valid), 32'h1 << q[0].idx);
      chk("rsp_data", ifa.rsp_data, q[0].data);
      void'(q.pop_front());
    end else begin
      chk("rsp_idle", 32'(ifa.rsp_valid), 32'h0);
    end
    @(posedge clk);
    if (g >= 0) begin
      m_run  = (g == m_last) ? m_run + 1 : 1;
      m_last = g;
      m_rr   = g;
      if (we[g]) shadow[ga[15:2]] = gd;
      else q.push_back('{due: cyc + RL, idx: g, data: shadow[ga[15:2]]});
    end else begin
      m_last = -1;
      m_run  = 0;
    end
    cyc++;
  endtask

  // One cycle in reset with requests asserted, then one idle cycle after release
  task automatic pulse_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    ifa.req    = 2'b11;
    ifa.req_we = 2'b01;
    ifb.req    = 3'b111;
    #1;
    chk("rst_gnt", 32'(ifa.gnt), 32'h0);
    chk("rst_wen", 32'(ifa.mem_wen), 32'h0);
    chk("rst_rsp", 32'(ifa.rsp_valid), 32'h0);
    chk("rst_gnt_b", 32'(ifb.gnt), 32'h0);
    @(negedge clk);
    rst_n   = 1'b1;
    ifa.req = 2'b00;
    ifb.req = 3'b000;
    model_reset();
    #1;
    chk("post_rst_rsp", 32'(ifa.rsp_valid), 32'h0);
    chk("post_rst_gnt", 32'(ifa.gnt), 32'h0);
    @(posedge clk);
    cyc += 2;
  endtask

  function automatic logic [31:0] waddr(input int w);
    logic [31:0] h;
    h = $urandom;
    return {h[31:16], 10'b0, w[3:0], h[1:0]};
  endfunction

  initial begin
    n_chk = 0; n_err = 0; cyc = 0;
    for (int i = 0; i < 16384; i++) shadow[i] = 32'h0;
    model_reset();
    ifa.req = '0; ifa.req_we = '0; ifa.req_addr = '0; ifa.req_wdata = '0;
    ifb.req = '0; ifb.req_we = '0; ifb.req_addr = '0; ifb.req_wdata = '0;

    // Reset state with requests pending
    repeat (2) @(negedge clk);
    ifa.req = 2'b11;
    ifb.req = 3'b101;
    #1;
    chk("init_gnt", 32'(ifa.gnt), 32'h0);
    chk("init_rsp", 32'(ifa.rsp_valid), 32'h0);
    chk("init_wen", 32'(ifa.mem_wen), 32'h0);
    chk("init_gnt_b", 32'(ifb.gnt), 32'h0);
    @(negedge clk);
    rst_n   = 1'b1;
    ifa.req = '0;
    ifb.req = '0;

    // Write then read 0x10 from requester 0
    cycle(2'b01, 2'b01, 32'h10, 32'h0, 32'hDEADBEEF, 32'h0);
    cycle(2'b01, 2'b00, 32'h10, 32'h0, 32'h0, 32'h0);
    repeat (3) cycle(2'b00, 2'b00, 0, 0, 0, 0);

    // Preload the 16 words used below
    for (int w = 0; w < 16; w++) begin
      cycle(2'b10, 2'b10, 0, waddr(w), 0, $urandom);
      cycle(2'b00, 2'b00, 0, 0, 0, 0);
    end

    // Both requesting reads: bursts of 4 alternate
    for (int i = 0; i < 12; i++)
      cycle(2'b11, 2'b00, waddr(i), waddr(15 - i), 0, 0);
    repeat (3) cycle(2'b00, 2'b00, 0, 0, 0, 0);

    // A=1, B=2 then consecutive reads by different requesters
    cycle(2'b01, 2'b01, 32'h20, 0, 32'h1, 0);
    cycle(2'b10, 2'b10, 0, 32'h24, 0, 32'h2);
    cycle(2'b00, 2'b00, 0, 0, 0, 0);
    cycle(2'b01, 2'b00, 32'h20, 0, 0, 0);
    cycle(2'b10, 2'b00, 0, 32'h24, 0, 0);
    repeat (3) cycle(2'b00, 2'b00, 0, 0, 0, 0);

    // Requester 1 alone then both: 1 holds for 4, then 0
    cycle(2'b10, 2'b00, 0, 32'h24, 0, 0);
    repeat (5) cycle(2'b11, 2'b00, 32'h20, 32'h24, 0, 0);
    repeat (3) cycle(2'b00, 2'b00, 0, 0, 0, 0);

    // Two reads in flight, then reset before they return
    cycle(2'b01, 2'b00, 32'h20, 0, 0, 0);
    cycle(2'b10, 2'b00, 0, 32'h24, 0, 0);
    pulse_reset();
    repeat (3) cycle(2'b00, 2'b00, 0, 0, 0, 0);

    // Randomized traffic over the preloaded words
    for (int i = 0; i < 600; i++) begin
      logic [1:0] r, we;
      r[0] = ($urandom_range(0, 9) < 6);
      r[1] = ($urandom_range(0, 9) < 6);
      we   = 2'($urandom_range(0, 3));
      cycle(r, we, waddr($urandom_range(0, 15)), waddr($urandom_range(0, 15)),
            $urandom, $urandom);
      if ($urandom_range(0, 99) == 0) pulse_reset();
    end
    repeat (3) cycle(2'b00, 2'b00, 0, 0, 0, 0);
    chk("rsp_drained", 32'(q.size()), 32'h0);

    // NREQ=3, MAX_BURST=1, req=101: strict 0,2 alternation, 1 never granted
    pulse_reset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      ifb.req         = 3'b101;
      ifb.req_we      = 3'b000;
      ifb.req_addr[0] = 32'h100;
      ifb.req_addr[1] = 32'h200;
      ifb.req_addr[2] = 32'h300;
      #1;
      chk("b_gnt", 32'(ifb.gnt), (k % 2 == 0) ? 32'h1 : 32'h4);
      chk("b_raddr", ifb.mem_raddr, (k % 2 == 0) ? 32'h100 : 32'h300);
      @(posedge clk);
    end
    @(negedge clk);
    ifb.req = '0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
